// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-access stage: op encodings,
// FSM states and the default RAM address width.
package mem_access_pkg;

    localparam int unsigned ADDR_W_DEF = 17;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_load(input mem_op_e op);
        logic r;
        r = (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
        return r;
    endfunction

    function automatic logic is_store(input mem_op_e op);
        logic r;
        r = (op == SB) || (op == SH) || (op == SW);
        return r;
    endfunction

    // Number of bytes moved by an op (0 for non-memory ops).
    function automatic logic [2:0] op_bytes(input mem_op_e op);
        logic [2:0] r;
        case (op)
            LB, LBU, SB: r = 3'd1;
            LH, LHU, SH: r = 3'd2;
            LW, SW:      r = 3'd4;
            default:     r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Combinational sign/zero extension of assembled load bytes.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] raw_data,
    input  logic [3:0]  mem_op,
    output logic [31:0] wdata
);

    // Extend according to load width and signedness; other ops pass through.
    always_comb begin
        wdata = raw_data;
        case (mem_op_e'(mem_op))
            LB:      wdata = {{24{raw_data[7]}}, raw_data[7:0]};
            LH:      wdata = {{16{raw_data[15]}}, raw_data[15:0]};
            LBU:     wdata = {24'd0, raw_data[7:0]};
            LHU:     wdata = {16'd0, raw_data[15:0]};
            default: wdata = raw_data;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: ALU pass-through plus byte-serial loads/stores over
// a single-port, 1-cycle-latency RAM bus, stalling the pipe while busy.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [3:0]        mem_op,
    input  logic              we_in,
    input  logic [4:0]        waddr_in,
    input  logic [31:0]       wdata_in,
    input  logic [31:0]       store_data,
    input  logic              hold,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic              we,
    output logic [4:0]        waddr,
    output logic [31:0]       wdata,
    output logic              stall_req
);

    mem_op_e             op;
    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          dout_q, dout_d;
    logic                wr_q, wr_d;
    logic [31:0]         data_q, data_d;
    mem_op_e             op_q, op_d;
    logic                we_q, we_d;
    logic [4:0]          waddr_q, waddr_d;
    logic [2:0]          n_q;
    logic [1:0]          cap_idx;
    logic [1:0]          nxt_idx;
    logic [31:0]         ext_data;

    assign op      = mem_op_e'(mem_op);
    assign n_q     = op_bytes(op_q);
    assign cap_idx = cnt_q[1:0] - 2'd1;
    assign nxt_idx = cnt_q[1:0] + 2'd1;

    load_extend u_load_extend (
        .raw_data (data_q),
        .mem_op   (op_q),
        .wdata    (ext_data)
    );

    // State register and transfer datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            op_q    <= MEM_NONE;
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
        end
    end

    // Next-state: issue addresses, capture load bytes, stream store bytes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        wr_d    = wr_q;
        data_d  = data_q;
        op_d    = op_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (is_load(op) || is_store(op)) begin
                        addr_d  = wdata_in[ADDR_W-1:0];
                        cnt_d   = '0;
                        data_d  = wdata_in;
                        op_d    = op;
                        we_d    = we_in;
                        waddr_d = waddr_in;
                        if (is_load(op)) begin
                            state_d = RD;
                        end else begin
                            state_d = WR;
                            dout_d  = store_data[7:0];
                            wr_d    = 1'b1;
                        end
                    end
                end
                // cnt_q is the address index being issued; byte cnt_q-1 arrives now.
                RD: begin
                    if (cnt_q != 3'd0) begin
                        case (cap_idx)
                            2'd0: data_d[7:0]   = ram_din;
                            2'd1: data_d[15:8]  = ram_din;
                            2'd2: data_d[23:16] = ram_din;
                            2'd3: data_d[31:24] = ram_din;
                            default: ;
                        endcase
                    end
                    if ((cnt_q + 3'd1) < n_q) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    if (cnt_q == n_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                WR: begin
                    if ((cnt_q + 3'd1) == n_q) begin
                        wr_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        addr_d = addr_q + ADDR_W'(1);
                        case (nxt_idx)
                            2'd0: dout_d = store_data[7:0];
                            2'd1: dout_d = store_data[15:8];
                            2'd2: dout_d = store_data[23:16];
                            2'd3: dout_d = store_data[31:24];
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    if (!hold) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: pass-through in IDLE, stall while busy, registered result in DONE.
    always_comb begin
        we        = 1'b0;
        waddr     = waddr_in;
        wdata     = wdata_in;
        stall_req = 1'b0;
        ram_addr  = addr_q;
        ram_dout  = dout_q;
        ram_wr    = wr_q & rdy;
        if (rst) begin
            waddr    = '0;
            wdata    = '0;
            ram_addr = '0;
            ram_dout = '0;
            ram_wr   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_load(op) || is_store(op)) begin
                        stall_req = 1'b1;
                    end else begin
                        we = we_in;
                    end
                end
                RD, WR: begin
                    stall_req = 1'b1;
                end
                DONE: begin
                    we    = we_q & is_load(op_q);
                    waddr = waddr_q;
                    wdata = ext_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with a byte RAM model.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          rst, rdy, we_in, hold;
    logic [3:0]    mem_op;
    logic [4:0]    waddr_in;
    logic [31:0]   wdata_in, store_data;
    logic [7:0]    ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_wr, we, stall_req;
    logic [4:0]    waddr;
    logic [31:0]   wdata;

    logic          tb_we;
    logic [AW-1:0] tb_a;
    logic [7:0]    tb_d;
    logic [7:0]    mem [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .mem_op     (mem_op),
        .we_in      (we_in),
        .waddr_in   (waddr_in),
        .wdata_in   (wdata_in),
        .store_data (store_data),
        .hold       (hold),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .ram_addr   (ram_addr),
        .ram_wr     (ram_wr),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .stall_req  (stall_req)
    );

    // Single-port RAM, 1-cycle read latency; it shares the global enable.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_dout;
        else if (tb_we) mem[tb_a] <= tb_d;
        if (rdy) ram_din <= mem[ram_addr];
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_a = a; tb_d = d;
        cyc();
        tb_we = 1'b0;
    endtask

    task automatic idle();
        cyc();
        mem_op = MEM_NONE; we_in = 1'b0; waddr_in = '0; wdata_in = '0; store_data = '0;
    endtask

    task automatic do_load(input string tag, input mem_op_e op, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] exp, input int n);
        mem_op = op; wdata_in = a; we_in = 1'b1; waddr_in = rd; store_data = '0;
        #1;
        chk({tag, " T0 stall"}, {31'd0, stall_req}, 32'd1);
        for (int i = 0; i < n; i++) begin
            cyc(); #1;
            chk({tag, " addr"}, {15'd0, ram_addr}, (a + i) & 32'h1FFFF);
            chk({tag, " stall"}, {31'd0, stall_req}, 32'd1);
        end
        cyc(); #1;
        chk({tag, " last stall"}, {31'd0, stall_req}, 32'd1);
        cyc(); #1;
        chk({tag, " done stall"}, {31'd0, stall_req}, 32'd0);
        chk({tag, " we"}, {31'd0, we}, 32'd1);
        chk({tag, " waddr"}, {27'd0, waddr}, {27'd0, rd});
        chk({tag, " wdata"}, wdata, exp);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; hold = 1'b0; tb_we = 1'b0; tb_a = '0; tb_d = '0;
        mem_op = MEM_NONE; we_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'h55; store_data = 32'hFFFF_FFFF;
        poke(17'h00100, 8'h78); poke(17'h00101, 8'h56);
        poke(17'h00102, 8'h34); poke(17'h00103, 8'h12);
        poke(17'h00200, 8'h80);
        poke(17'h00300, 8'h01); poke(17'h00301, 8'h80);
        poke(17'h00002, 8'h77); poke(17'h00501, 8'h99);
        #1;
        chk("rst we",        {31'd0, we}, 32'd0);
        chk("rst waddr",     {27'd0, waddr}, 32'd0);
        chk("rst wdata",     wdata, 32'd0);
        chk("rst stall",     {31'd0, stall_req}, 32'd0);
        chk("rst ram_wr",    {31'd0, ram_wr}, 32'd0);
        chk("rst ram_addr",  {15'd0, ram_addr}, 32'd0);
        chk("rst ram_dout",  {24'd0, ram_dout}, 32'd0);

        rst = 1'b0;
        cyc();
        mem_op = MEM_NONE; we_in = 1'b1; waddr_in = 5'd5; wdata_in = 32'h0000_002A;
        #1;
        chk("add we",    {31'd0, we}, 32'd1);
        chk("add waddr", {27'd0, waddr}, 32'd5);
        chk("add wdata", wdata, 32'h2A);
        chk("add stall", {31'd0, stall_req}, 32'd0);

        idle(); do_load("lw",  LW,  32'h100, 5'd10, 32'h1234_5678, 4);
        idle(); do_load("lb",  LB,  32'h200, 5'd11, 32'hFFFF_FF80, 1);
        idle(); do_load("lbu", LBU, 32'h200, 5'd12, 32'h0000_0080, 1);
        idle(); do_load("lh",  LH,  32'h300, 5'd13, 32'hFFFF_8001, 2);

        // SW with address wrap
        idle();
        mem_op = SW; wdata_in = 32'h0001_FFFE; store_data = 32'hDEAD_BEEF; we_in = 1'b1; waddr_in = 5'd3;
        #1;
        chk("sw T0 stall", {31'd0, stall_req}, 32'd1);
        chk("sw T0 ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("sw T0 we", {31'd0, we}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("sw ram_wr", {31'd0, ram_wr}, 32'd1);
            chk("sw addr", {15'd0, ram_addr}, (32'h1FFFE + i) & 32'h1FFFF);
            chk("sw dout", {24'd0, ram_dout}, (32'hDEAD_BEEF >> (8 * i)) & 32'hFF);
            chk("sw we", {31'd0, we}, 32'd0);
            chk("sw stall", {31'd0, stall_req}, 32'd1);
        end
        cyc(); #1;
        chk("sw done ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("sw done stall", {31'd0, stall_req}, 32'd0);
        chk("sw done we", {31'd0, we}, 32'd0);
        chk("sw mem 1fffe", {24'd0, mem[17'h1FFFE]}, 32'hEF);
        chk("sw mem 1ffff", {24'd0, mem[17'h1FFFF]}, 32'hBE);
        chk("sw mem 00000", {24'd0, mem[17'h00000]}, 32'hAD);
        chk("sw mem 00001", {24'd0, mem[17'h00001]}, 32'hDE);
        chk("sw mem 00002", {24'd0, mem[17'h00002]}, 32'h77);

        // hold in DONE
        idle(); do_load("lwh", LW, 32'h100, 5'd12, 32'h1234_5678, 4);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("hold wdata", wdata, 32'h1234_5678);
            chk("hold we", {31'd0, we}, 32'd1);
            chk("hold stall", {31'd0, stall_req}, 32'd0);
            chk("hold addr", {15'd0, ram_addr}, 32'h103);
            chk("hold ram_wr", {31'd0, ram_wr}, 32'd0);
        end
        hold = 1'b0;

        // rdy low for 2 cycles mid-LW
        idle();
        mem_op = LW; wdata_in = 32'h100; we_in = 1'b1; waddr_in = 5'd9;
        #1; chk("rdy T0 stall", {31'd0, stall_req}, 32'd1);
        cyc(); #1; chk("rdy T1 addr", {15'd0, ram_addr}, 32'h100);
        cyc(); #1; chk("rdy T2 addr", {15'd0, ram_addr}, 32'h101);
        rdy = 1'b0;
        cyc(); #1;
        chk("rdy T3 addr", {15'd0, ram_addr}, 32'h101);
        chk("rdy T3 stall", {31'd0, stall_req}, 32'd1);
        chk("rdy T3 ram_wr", {31'd0, ram_wr}, 32'd0);
        cyc(); #1;
        chk("rdy T4 stall", {31'd0, stall_req}, 32'd1);
        rdy = 1'b1;
        cyc(); #1; chk("rdy T5 addr", {15'd0, ram_addr}, 32'h102);
        cyc(); #1; chk("rdy T6 addr", {15'd0, ram_addr}, 32'h103);
        cyc(); #1; chk("rdy T7 stall", {31'd0, stall_req}, 32'd1);
        cyc(); #1;
        chk("rdy T8 stall", {31'd0, stall_req}, 32'd0);
        chk("rdy T8 wdata", wdata, 32'h1234_5678);

        // reset in T2 of a SW
        idle();
        mem_op = SW; wdata_in = 32'h500; store_data = 32'h1122_3344; we_in = 1'b1; waddr_in = 5'd4;
        cyc(); #1;
        chk("rsw T1 dout", {24'd0, ram_dout}, 32'h44);
        cyc(); #1;
        chk("rsw T2 ram_wr", {31'd0, ram_wr}, 32'd1);
        chk("rsw T2 addr", {15'd0, ram_addr}, 32'h501);
        rst = 1'b1;
        #1;
        chk("rsw rst ram_wr", {31'd0, ram_wr}, 32'd0);
        cyc();
        rst = 1'b0; mem_op = MEM_NONE; we_in = 1'b0; waddr_in = '0; wdata_in = '0; store_data = '0;
        #1;
        chk("rsw ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rsw ram_addr", {15'd0, ram_addr}, 32'd0);
        chk("rsw ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rsw stall", {31'd0, stall_req}, 32'd0);
        chk("rsw we", {31'd0, we}, 32'd0);
        chk("rsw waddr", {27'd0, waddr}, 32'd0);
        chk("rsw wdata", wdata, 32'd0);
        chk("rsw mem 500", {24'd0, mem[17'h00500]}, 32'h44);
        chk("rsw mem 501", {24'd0, mem[17'h00501]}, 32'h99);
        do_load("lw2", LW, 32'h100, 5'd15, 32'h1234_5678, 4);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
